// File: rtl/punc_pkg.sv
// Shared encodings for the PUNC multi-cycle datapath: opcodes, FSM states, condition codes.
package punc_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_FETCH = 4'd1,
    OP_ADD   = 4'd2,
    OP_AND   = 4'd3,
    OP_NOT   = 4'd4,
    OP_LEA   = 4'd5,
    OP_LD    = 4'd6,
    OP_LDR   = 4'd7,
    OP_LDI   = 4'd8,
    OP_ST    = 4'd9,
    OP_STR   = 4'd10,
    OP_BR    = 4'd11,
    OP_JMP   = 4'd12,
    OP_JSR   = 4'd13
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_MEM2 = 2'd2
  } state_e;

  localparam logic [2:0] NZP_N = 3'b100;
  localparam logic [2:0] NZP_Z = 3'b010;
  localparam logic [2:0] NZP_P = 3'b001;

  // Ops that leave IDLE and run a memory transfer.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_FETCH) || (op == OP_LD) || (op == OP_LDR) ||
           (op == OP_LDI) || (op == OP_ST) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/punc_regfile.sv
// Register file: two operand reads, one debug read, one write; reads return pre-write value.
module punc_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] ra1,
  input  logic [$clog2(NREGS)-1:0] ra2,
  output logic [WIDTH-1:0]         rd1,
  output logic [WIDTH-1:0]         rd2,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic [WIDTH-1:0]         wd
);

  logic [NREGS-1:0][WIDTH-1:0] regs;

  assign rd1      = regs[ra1];
  assign rd2      = regs[ra2];
  assign dbg_data = regs[dbg_addr];

  // Single write port; async clear of the whole array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs <= '0;
    else if (we) regs[wa] <= wd;
  end

endmodule

// File: rtl/punc_mc_datapath.sv
// PUNC multi-cycle datapath: single-cycle ALU/control ops, multi-cycle memory ops over a req/ack bus.
module punc_mc_datapath import punc_pkg::*; #(
  parameter int               WIDTH  = 16,
  parameter int               NREGS  = 8,
  parameter logic [WIDTH-1:0] PC_RST = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [$clog2(NREGS)-1:0] cmd_dst,
  input  logic [$clog2(NREGS)-1:0] cmd_src1,
  input  logic [$clog2(NREGS)-1:0] cmd_src2,
  input  logic [WIDTH-1:0]         cmd_imm,
  input  logic                     cmd_imm_sel,
  output logic                     done,
  output logic [2:0]               nzp,
  output logic [WIDTH-1:0]         ir,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata,
  input  logic                     mem_ack,
  input  logic [$clog2(NREGS)-1:0] rf_debug_addr,
  output logic [WIDTH-1:0]         rf_debug_data,
  output logic [WIDTH-1:0]         pc_debug_data
);

  localparam int AW = $clog2(NREGS);

  state_e           state, state_nx;
  logic [WIDTH-1:0] pc;
  logic [3:0]       pend_op;
  logic [AW-1:0]    pend_dst;
  logic [WIDTH-1:0] rd1, rd2, opb, pc_imm, maddr, rf_wd;
  logic [AW-1:0]    rf_wa;
  logic             rf_we, set_cc, accept, xfer, load_done;

  function automatic logic [2:0] cc(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) return NZP_N;
    if (v == '0)    return NZP_Z;
    return NZP_P;
  endfunction

  assign cmd_ready     = (state == S_IDLE);
  assign accept        = cmd_valid && cmd_ready;
  assign xfer          = mem_req && mem_ack;
  assign opb           = cmd_imm_sel ? cmd_imm : rd2;
  assign pc_imm        = pc + cmd_imm;
  assign pc_debug_data = pc;
  assign load_done     = xfer && ((state == S_MEM2) ||
                         ((state == S_MEM) && ((pend_op == OP_LD) || (pend_op == OP_LDR))));

  punc_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra1      (cmd_src1),
    .ra2      (cmd_src2),
    .rd1      (rd1),
    .rd2      (rd2),
    .dbg_addr (rf_debug_addr),
    .dbg_data (rf_debug_data),
    .we       (rf_we),
    .wa       (rf_wa),
    .wd       (rf_wd)
  );

  // Register write port: ALU/LEA/JSR results at accept, load data at the final ack.
  always_comb begin
    rf_we  = 1'b0;
    rf_wa  = cmd_dst;
    rf_wd  = mem_rdata;
    set_cc = 1'b0;
    if (accept) begin
      case (cmd_op)
        OP_ADD:  begin rf_we = 1'b1; rf_wd = rd1 + opb; set_cc = 1'b1; end
        OP_AND:  begin rf_we = 1'b1; rf_wd = rd1 & opb; set_cc = 1'b1; end
        OP_NOT:  begin rf_we = 1'b1; rf_wd = ~rd1;      set_cc = 1'b1; end
        OP_LEA:  begin rf_we = 1'b1; rf_wd = pc_imm; end
        OP_JSR:  begin rf_we = 1'b1; rf_wa = AW'(NREGS-1); rf_wd = pc; end
        default: ;
      endcase
    end else if (load_done) begin
      rf_we  = 1'b1;
      rf_wa  = pend_dst;
      set_cc = 1'b1;
    end
  end

  // First memory address for the accepted op.
  always_comb begin
    case (cmd_op)
      OP_FETCH:       maddr = pc;
      OP_LDR, OP_STR: maddr = rd1 + cmd_imm;
      default:        maddr = pc_imm;
    endcase
  end

  // FSM next state: IDLE -> MEM [-> MEM2 for LDI] -> IDLE on acks.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept && is_mem_op(cmd_op)) state_nx = S_MEM;
      S_MEM:   if (xfer) state_nx = (pend_op == OP_LDI) ? S_MEM2 : S_IDLE;
      S_MEM2:  if (xfer) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // PC, IR, condition codes, done pulse and memory bus registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= PC_RST;
      ir        <= '0;
      nzp       <= NZP_Z;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pend_op   <= OP_NOP;
      pend_dst  <= '0;
    end else begin
      done <= 1'b0;
      if (set_cc) nzp <= cc(rf_wd);
      case (state)
        S_IDLE: if (accept) begin
          pend_op  <= cmd_op;
          pend_dst <= cmd_dst;
          if (is_mem_op(cmd_op)) begin
            mem_req   <= 1'b1;
            mem_we    <= (cmd_op == OP_ST) || (cmd_op == OP_STR);
            mem_addr  <= maddr;
            mem_wdata <= rd2;
          end else begin
            done <= 1'b1;
            case (cmd_op)
              OP_BR:   if (|(cmd_dst[2:0] & nzp)) pc <= pc_imm;
              OP_JMP:  pc <= rd1;
              OP_JSR:  pc <= cmd_imm_sel ? pc_imm : rd1;
              default: ;
            endcase
          end
        end
        S_MEM: if (xfer) begin
          if (pend_op == OP_LDI) begin
            mem_addr <= mem_rdata;
          end else begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            if (pend_op == OP_FETCH) begin
              ir <= mem_rdata;
              pc <= pc + WIDTH'(1);
            end
          end
        end
        S_MEM2: if (xfer) begin
          mem_req <= 1'b0;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/punc_mc_datapath.md
PUNC_MC_DATAPATH -- requirements
Module: punc_mc_datapath

Interface
REQ-001 SHALL have parameters: WIDTH, default 16, datapath/address width; NREGS, default 8, register count (power of 2, >=8); PC_RST, default 0, PC reset value.
REQ-002 SHALL use one clock and asynchronous active-low reset, ports: clk  in  1  clock (rising edge); rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: cmd_valid  in  1  command offered; cmd_ready  out  1  datapath can accept.
REQ-004 SHALL have ports: cmd_op  in  4  operation; cmd_dst/cmd_src1/cmd_src2  in  log2(NREGS) each  register addresses; cmd_imm  in  WIDTH  pre-sign-extended immediate; cmd_imm_sel  in  1  use imm as operand 2.
REQ-005 SHALL have ports: done  out  1  one-cycle completion pulse; nzp  out  3  condition codes; ir  out  WIDTH  instruction register.
REQ-006 SHALL have ports: mem_req  out  1; mem_we  out  1; mem_addr  out  WIDTH; mem_wdata  out  WIDTH; mem_rdata  in  WIDTH; mem_ack  in  1 (variable-latency memory).
REQ-007 SHALL have debug ports: rf_debug_addr  in  log2(NREGS); rf_debug_data  out  WIDTH (combinational, pre-write value); pc_debug_data  out  WIDTH.

Function
REQ-008 SHALL accept a command on a rising edge with cmd_valid&&cmd_ready; cmd_ready = 1 only in state IDLE.
REQ-009 SHALL implement ops: 0 NOP, 1 FETCH (ir=mem[pc], pc+=1), 2 ADD, 3 AND, 4 NOT, 5 LEA (dst=pc+imm), 6 LD (mem[pc+imm]), 7 LDR (mem[src1+imm]), 8 LDI (mem[mem[pc+imm]]), 9 ST (mem[pc+imm]=src2), 10 STR (mem[src1+imm]=src2), 11 BR, 12 JMP (pc=src1), 13 JSR; 14-15 behave as NOP.
REQ-010 ADD/AND SHALL use operand 2 = imm if cmd_imm_sel else R[src2]; all arithmetic modulo 2^WIDTH.
REQ-011 BR SHALL load pc=pc+imm iff (cmd_dst[2:0] & nzp) != 0.
REQ-012 JSR SHALL write R[NREGS-1]=old pc and pc = imm_sel ? pc+imm : old R[src1].
REQ-013 Non-memory ops SHALL commit at the accept edge, pulse done the next cycle, and stay in IDLE (1 op/cycle throughput).
REQ-014 Memory ops SHALL move IDLE->MEM at accept; mem_req=1 in MEM with mem_addr/mem_we/mem_wdata stable until a cycle with mem_ack=1.
REQ-015 A transfer SHALL complete on each edge with mem_req&&mem_ack; mem_ack while mem_req=0 SHALL be ignored.
REQ-016 LDI SHALL perform MEM (addr pc+imm) -> MEM2 (addr = first rdata, mem_req kept high, no idle cycle) -> IDLE.
REQ-017 Read data SHALL be written at the final ack edge; done SHALL pulse the cycle after; state returns to IDLE at that edge.
REQ-018 nzp SHALL update from the written value on ADD, AND, NOT, LD, LDR, LDI only: exactly one bit set (N=100, Z=010, P=001).
REQ-019 A source register equal to the destination SHALL read the old value; debug read of a register written that edge SHALL return old value.
REQ-020 FETCH SHALL capture ir and increment pc on the ack edge; pc wraps 2^WIDTH-1 -> 0.

Reset
REQ-021 On rst=0, asynchronously: state=IDLE, pc=PC_RST, ir=0, all registers=0, nzp=010, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-022 Reset during MEM/MEM2 SHALL drop mem_req immediately and discard the pending op; no register/pc write.
REQ-023 cmd_ready SHALL be 1 from the first edge after rst release.

Structure
REQ-024 Op encodings, state encoding (IDLE, MEM, MEM2), NZP constants SHALL live in shared package punc_pkg.
REQ-025 Register file SHALL be sub-module punc_regfile (parametrised WIDTH/NREGS, 2 read + 1 debug read, 1 write, async active-low reset).

Verification
REQ-026 Reset, then FETCH with mem[0]=16'h1234, ack after 3 cycles -> ir=1234, pc=1, done one pulse, mem_req high exactly 3 cycles.
REQ-027 ADD R1=R0+imm 16'hFFFF, then ADD R2=R1+R1 back-to-back -> R1=FFFF, R2=FFFE, nzp=100 each, done two consecutive cycles.
REQ-028 LDI with pc=2, imm=3, mem[5]=16'h0040, mem[0x40]=16'h0000 -> addresses 5 then 40 consecutive, R[dst]=0, nzp=010.
REQ-029 BR cond=010 with nzp=001 -> pc unchanged; cond=011 -> pc=pc+imm; JSR from pc=0x10, imm=4 -> R7=0x10, pc=0x14.
REQ-030 Assert rst during LDI MEM2 wait -> mem_req=0 same cycle, R[dst] unchanged, pc=PC_RST, no done pulse.
